// File: rtl/cpu_pkg.sv
// Opcode constants and fetch-state encoding shared by the fetch stage and the
// control decoder.
package cpu_pkg;

  localparam logic [3:0] OP_NOOP     = 4'h0;
  localparam logic [3:0] OP_LAST_ALU = 4'h9;
  localparam logic [3:0] OP_JMP      = 4'hA;
  localparam logic [3:0] OP_HALT     = 4'hF;

  localparam logic [1:0] FETCH  = 2'd0;
  localparam logic [1:0] DECODE = 2'd1;
  localparam logic [1:0] HALT   = 2'd2;

  // Opcodes 0x1..0x9 are forwarded to the control decoder.
  function automatic logic is_issue_op(input logic [3:0] op);
    return (op != OP_NOOP) && (op <= OP_LAST_ALU);
  endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// ROM read port plus the issue port toward the control decoder.
interface instr_fetch_if #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned OPND_W = 8
);

  logic              mem_rd;
  logic [ADDR_W-1:0] mem_addr;
  logic [OPND_W+3:0] mem_data;
  logic [3:0]        instruction;
  logic [OPND_W-1:0] operand;
  logic              instr_valid;

  modport master (
    output mem_rd, mem_addr, instruction, operand, instr_valid,
    input  mem_data
  );

  modport slave (
    input  mem_rd, mem_addr, instruction, operand, instr_valid,
    output mem_data
  );

endinterface

// File: rtl/instr_fetch.sv
// Fetch/sequencer stage: owns the PC, reads the program ROM, resolves JMP and
// HALT locally and issues opcodes 0x1..0x9 as single-cycle pulses.
module instr_fetch
  import cpu_pkg::*;
#(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned OPND_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  instr_fetch_if.master     bus,
  output logic [ADDR_W-1:0] pc,
  output logic              halted
);

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              rd_q, rd_d;
  logic [3:0]        instr_q, instr_d;
  logic [OPND_W-1:0] opnd_q, opnd_d;
  logic              valid_q, valid_d;
  logic              halted_q, halted_d;

  logic [3:0]        op;
  logic [OPND_W-1:0] field;
  logic [ADDR_W-1:0] jmp_tgt;
  logic [ADDR_W-1:0] pc_inc;

  assign op      = bus.mem_data[OPND_W+3:OPND_W];
  assign field   = bus.mem_data[OPND_W-1:0];
  // Size cast truncates or zero-extends the operand to a PC-wide target.
  assign jmp_tgt = ADDR_W'(field);
  assign pc_inc  = pc_q + ADDR_W'(1);

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    addr_d   = addr_q;
    rd_d     = 1'b0;
    instr_d  = OP_NOOP;
    opnd_d   = opnd_q;
    valid_d  = 1'b0;
    halted_d = halted_q;
    case (state_q)
      FETCH: begin
        if (en) begin
          rd_d    = 1'b1;
          addr_d  = pc_q;
          state_d = DECODE;
        end
      end
      DECODE: begin
        state_d = FETCH;
        if (is_issue_op(op)) begin
          instr_d = op;
          opnd_d  = field;
          valid_d = 1'b1;
          pc_d    = pc_inc;
        end else if (op == OP_JMP) begin
          pc_d = jmp_tgt;
        end else if (op == OP_HALT) begin
          halted_d = 1'b1;
          state_d  = HALT;
        end else begin
          pc_d = pc_inc;
        end
      end
      HALT: begin
        state_d = HALT;
      end
      default: begin
        state_d = FETCH;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= FETCH;
      pc_q     <= '0;
      addr_q   <= '0;
      rd_q     <= 1'b0;
      instr_q  <= OP_NOOP;
      opnd_q   <= '0;
      valid_q  <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      addr_q   <= addr_d;
      rd_q     <= rd_d;
      instr_q  <= instr_d;
      opnd_q   <= opnd_d;
      valid_q  <= valid_d;
      halted_q <= halted_d;
    end
  end

  assign bus.mem_rd      = rd_q;
  assign bus.mem_addr    = addr_q;
  assign bus.instruction = instr_q;
  assign bus.operand     = opnd_q;
  assign bus.instr_valid = valid_q;
  assign pc              = pc_q;
  assign halted          = halted_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: one 8-bit-address instance for the main
// scenarios and a 4-bit-address instance for PC wrap-around.
module tb_instr_fetch;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  // Main instance, ADDR_W=8
  logic        rst_n, en;
  logic [7:0]  pc;
  logic        halted;
  logic [11:0] rom [256];
  instr_fetch_if #(.ADDR_W(8), .OPND_W(8)) bus ();
  // The DUT's registered mem_addr acts as the ROM's read-address register.
  assign bus.mem_data = bus.mem_rd ? rom[bus.mem_addr] : '0;

  instr_fetch #(.ADDR_W(8), .OPND_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .bus(bus), .pc(pc), .halted(halted)
  );

  // Wrap instance, ADDR_W=4
  logic        rst2_n, en2;
  logic [3:0]  pc2;
  logic        halted2;
  logic [11:0] rom2 [16];
  instr_fetch_if #(.ADDR_W(4), .OPND_W(8)) bus2 ();
  assign bus2.mem_data = bus2.mem_rd ? rom2[bus2.mem_addr] : '0;

  instr_fetch #(.ADDR_W(4), .OPND_W(8)) dut2 (
    .clk(clk), .rst_n(rst2_n), .en(en2), .bus(bus2), .pc(pc2), .halted(halted2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b0; rst2_n = 1'b0; en2 = 1'b0;
    for (int i = 0; i < 256; i++) rom[i] = '0;
    for (int i = 0; i < 16; i++) rom2[i] = '0;
    rom[0] = 12'h105; rom[1] = 12'h7AA; rom[2] = 12'h900; rom[3] = 12'hA01;
    rom2[0] = 12'h400;
    #12;
    checks++;
    if ({bus.mem_rd, bus.mem_addr, bus.instruction, bus.operand, bus.instr_valid, pc, halted} !== '0)
      $display("FAIL reset_outputs: got rd=%b addr=%h ins=%h opnd=%h v=%b pc=%h h=%b, want all 0",
               bus.mem_rd, bus.mem_addr, bus.instruction, bus.operand, bus.instr_valid, pc, halted);
    else passes++;
    checks++;
    if ({bus2.mem_rd, bus2.instr_valid, pc2, halted2} !== '0)
      $display("FAIL reset_outputs_w4: got rd=%b v=%b pc=%h h=%b, want 0",
               bus2.mem_rd, bus2.instr_valid, pc2, halted2);
    else passes++;
    @(negedge clk);
    rst_n = 1'b1;
    en    = 1'b1;
  endtask

  task automatic test_basic_issue();
    tick();
    checks++;
    if (bus.mem_rd !== 1'b1 || bus.mem_addr !== 8'h00 || bus.instr_valid !== 1'b0)
      $display("FAIL first_fetch: got rd=%b addr=%h v=%b, want rd=1 addr=00 v=0",
               bus.mem_rd, bus.mem_addr, bus.instr_valid);
    else passes++;
    tick();
    checks++;
    if (bus.instr_valid !== 1'b1 || bus.instruction !== 4'h1 || bus.operand !== 8'h05 || pc !== 8'd1)
      $display("FAIL issue_1: got v=%b ins=%h opnd=%h pc=%h, want 1/1/05/01",
               bus.instr_valid, bus.instruction, bus.operand, pc);
    else passes++;
    tick();
    checks++;
    if (bus.instr_valid !== 1'b0 || bus.instruction !== 4'h0 || bus.operand !== 8'h05 ||
        bus.mem_rd !== 1'b1 || bus.mem_addr !== 8'h01)
      $display("FAIL gap_after_1: got v=%b ins=%h opnd=%h rd=%b addr=%h, want 0/0/05/1/01",
               bus.instr_valid, bus.instruction, bus.operand, bus.mem_rd, bus.mem_addr);
    else passes++;
    tick();
    checks++;
    if (bus.instr_valid !== 1'b1 || bus.instruction !== 4'h7 || bus.operand !== 8'hAA)
      $display("FAIL issue_7: got v=%b ins=%h opnd=%h, want 1/7/AA",
               bus.instr_valid, bus.instruction, bus.operand);
    else passes++;
    tick();
    tick();
    checks++;
    if (bus.instr_valid !== 1'b1 || bus.instruction !== 4'h9 || bus.operand !== 8'h00 || pc !== 8'd3)
      $display("FAIL issue_9: got v=%b ins=%h opnd=%h pc=%h, want 1/9/00/03",
               bus.instr_valid, bus.instruction, bus.operand, pc);
    else passes++;
  endtask

  task automatic test_jmp_halt();
    bit bad;
    rom[1] = 12'h200;
    rom[2] = 12'hF00;
    tick();
    checks++;
    if (bus.mem_rd !== 1'b1 || bus.mem_addr !== 8'h03)
      $display("FAIL fetch_jmp: got rd=%b addr=%h, want 1/03", bus.mem_rd, bus.mem_addr);
    else passes++;
    tick();
    checks++;
    if (bus.instr_valid !== 1'b0 || pc !== 8'd1)
      $display("FAIL jmp: got v=%b pc=%h, want 0/01", bus.instr_valid, pc);
    else passes++;
    tick();
    tick();
    checks++;
    if (bus.instr_valid !== 1'b1 || bus.instruction !== 4'h2 || pc !== 8'd2)
      $display("FAIL issue_after_jmp: got v=%b ins=%h pc=%h, want 1/2/02",
               bus.instr_valid, bus.instruction, pc);
    else passes++;
    tick();
    tick();
    checks++;
    if (halted !== 1'b1 || pc !== 8'd2 || bus.instr_valid !== 1'b0)
      $display("FAIL halt: got h=%b pc=%h v=%b, want 1/02/0", halted, pc, bus.instr_valid);
    else passes++;
    bad = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (bus.mem_rd !== 1'b0 || bus.instr_valid !== 1'b0 || halted !== 1'b1 || pc !== 8'd2) bad = 1'b1;
    end
    checks++;
    if (bad) $display("FAIL halt_sticky: activity seen after HALT (rd=%b v=%b h=%b pc=%h), want none",
                      bus.mem_rd, bus.instr_valid, halted, pc);
    else passes++;
  endtask

  task automatic test_stall();
    bit bad;
    @(negedge clk);
    rst_n = 1'b0; en = 1'b0;
    rom[0] = 12'h542; rom[1] = 12'h311; rom[2] = 12'hCFF; rom[3] = 12'h677;
    #1;
    checks++;
    if (halted !== 1'b0 || pc !== 8'd0)
      $display("FAIL halt_cleared: got h=%b pc=%h, want 0/00", halted, pc);
    else passes++;
    @(negedge clk);
    rst_n = 1'b1;
    bad = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (bus.mem_rd !== 1'b0 || bus.instr_valid !== 1'b0 || pc !== 8'd0) bad = 1'b1;
    end
    checks++;
    if (bad) $display("FAIL stall: got rd=%b v=%b pc=%h during en=0, want 0/0/00",
                      bus.mem_rd, bus.instr_valid, pc);
    else passes++;
    @(negedge clk);
    en = 1'b1;
    tick();
    checks++;
    if (bus.mem_rd !== 1'b1 || bus.mem_addr !== 8'h00)
      $display("FAIL resume: got rd=%b addr=%h, want 1/00", bus.mem_rd, bus.mem_addr);
    else passes++;
    tick();
    checks++;
    if (bus.instr_valid !== 1'b1 || bus.instruction !== 4'h5 || bus.operand !== 8'h42 || pc !== 8'd1)
      $display("FAIL issue_5: got v=%b ins=%h opnd=%h pc=%h, want 1/5/42/01",
               bus.instr_valid, bus.instruction, bus.operand, pc);
    else passes++;
  endtask

  task automatic test_en_drop();
    bit bad;
    tick();
    en = 1'b0;
    tick();
    checks++;
    if (bus.instr_valid !== 1'b1 || bus.instruction !== 4'h3 || bus.operand !== 8'h11 || pc !== 8'd2)
      $display("FAIL issue_3_en_drop: got v=%b ins=%h opnd=%h pc=%h, want 1/3/11/02",
               bus.instr_valid, bus.instruction, bus.operand, pc);
    else passes++;
    bad = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (bus.mem_rd !== 1'b0 || pc !== 8'd2) bad = 1'b1;
    end
    checks++;
    if (bad) $display("FAIL stall_after_drop: got rd=%b pc=%h, want 0/02", bus.mem_rd, pc);
    else passes++;
  endtask

  task automatic test_reserved();
    en = 1'b1;
    tick();
    tick();
    checks++;
    if (bus.instr_valid !== 1'b0 || bus.instruction !== 4'h0 || pc !== 8'd3 || bus.operand !== 8'h11)
      $display("FAIL reserved_C: got v=%b ins=%h pc=%h opnd=%h, want 0/0/03/11",
               bus.instr_valid, bus.instruction, pc, bus.operand);
    else passes++;
  endtask

  task automatic test_reset_mid_decode();
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.mem_rd, bus.mem_addr, bus.instruction, bus.operand, bus.instr_valid, pc, halted} !== '0)
      $display("FAIL async_reset: got rd=%b addr=%h ins=%h opnd=%h v=%b pc=%h h=%b, want all 0",
               bus.mem_rd, bus.mem_addr, bus.instruction, bus.operand, bus.instr_valid, pc, halted);
    else passes++;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    checks++;
    if (bus.mem_rd !== 1'b1 || bus.mem_addr !== 8'h00)
      $display("FAIL restart_fetch: got rd=%b addr=%h, want 1/00", bus.mem_rd, bus.mem_addr);
    else passes++;
    tick();
    checks++;
    if (bus.instr_valid !== 1'b1 || bus.instruction !== 4'h5)
      $display("FAIL restart_issue: got v=%b ins=%h, want 1/5", bus.instr_valid, bus.instruction);
    else passes++;
    en = 1'b0;
  endtask

  task automatic test_wrap();
    @(negedge clk);
    rst2_n = 1'b1;
    en2    = 1'b1;
    for (int cyc = 1; cyc <= 66; cyc++) begin
      logic exp_v;
      tick();
      exp_v = ((cyc % 32) == 2);
      checks++;
      if (bus2.instr_valid !== exp_v || (exp_v && bus2.instruction !== 4'h4))
        $display("FAIL wrap_issue cyc %0d: got v=%b ins=%h, want v=%b ins=4",
                 cyc, bus2.instr_valid, bus2.instruction, exp_v);
      else passes++;
      if (cyc == 30) begin
        checks++;
        if (pc2 !== 4'd15) $display("FAIL wrap_pc15: got pc=%h, want f", pc2);
        else passes++;
      end
      if (cyc == 32) begin
        checks++;
        if (pc2 !== 4'd0) $display("FAIL wrap_pc0: got pc=%h, want 0", pc2);
        else passes++;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic_issue();
    test_jmp_halt();
    test_stall();
    test_en_drop();
    test_reserved();
    test_reset_mid_decode();
    test_wrap();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
